// File: rtl/lcd_init_ctrl.sv
// lcd_init_ctrl: panel ID strap sampling, reset sequencing and backlight enable after driver start
module lcd_init_ctrl #(
    parameter int T_SETTLE   = 1000,
    parameter int ID_SAMPLES = 4,
    parameter int T_RST      = 50000,
    parameter int BL_FRAMES  = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        restart,
    input  logic [23:0] lcd_rgb_i,
    input  logic        lcd_vs,
    output logic        drv_en,
    output logic        lcd_rst,
    output logic        lcd_bl,
    output logic [15:0] lcd_id,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic [1:0]  clk_sel,
    output logic        id_err
);
    typedef enum logic [2:0] {SETTLE, SAMPLE, RST_HOLD, RUN_WAIT, ON, ERROR} state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(T_SETTLE - 1);
    localparam logic [15:0] RST_LAST    = 16'(T_RST - 1);
    localparam logic [15:0] ID_N        = 16'(ID_SAMPLES);
    localparam logic [15:0] BL_N        = 16'(BL_FRAMES);

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx, mcnt, mcnt_nx, m_inc;
    logic [2:0]  code, code_q, code_nx, vs_q;
    logic        vs_rise, rgb_unused;
    logic        drv_en_nx, lcd_rst_nx, lcd_bl_nx, id_err_nx, dec_ok;
    logic [15:0] lcd_id_nx, dec_id;
    logic [10:0] h_nx, v_nx, dec_h, dec_v;
    logic [1:0]  clk_sel_nx, dec_clk;

    function automatic logic [15:0] sat(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    assign code       = {lcd_rgb_i[7], lcd_rgb_i[15], lcd_rgb_i[23]};
    assign rgb_unused = &{lcd_rgb_i[22:16], lcd_rgb_i[14:8], lcd_rgb_i[6:0]};
    assign vs_rise    = vs_q[1] & ~vs_q[2];
    assign m_inc      = (mcnt == 16'd0 || code == code_q) ? sat(mcnt) : 16'd1;

    always_comb begin
        dec_ok = 1'b1;
        {dec_id, dec_h, dec_v, dec_clk} = '0;
        case (code)
            3'b000:  {dec_id, dec_h, dec_v, dec_clk} = {16'h4342, 11'd480, 11'd272, 2'd0};
            3'b001:  {dec_id, dec_h, dec_v, dec_clk} = {16'h7084, 11'd800, 11'd480, 2'd1};
            3'b010:  {dec_id, dec_h, dec_v, dec_clk} = {16'h7016, 11'd1024, 11'd600, 2'd2};
            3'b100:  {dec_id, dec_h, dec_v, dec_clk} = {16'h4384, 11'd800, 11'd480, 2'd1};
            3'b101:  {dec_id, dec_h, dec_v, dec_clk} = {16'h1018, 11'd1280, 11'd800, 2'd3};
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        mcnt_nx    = mcnt;
        code_nx    = code_q;
        drv_en_nx  = drv_en;
        lcd_rst_nx = lcd_rst;
        lcd_bl_nx  = lcd_bl;
        id_err_nx  = id_err;
        lcd_id_nx  = lcd_id;
        h_nx       = h_disp;
        v_nx       = v_disp;
        clk_sel_nx = clk_sel;
        case (state)
            SETTLE: begin
                cnt_nx   = (cnt >= SETTLE_LAST) ? 16'd0 : sat(cnt);
                state_nx = (cnt >= SETTLE_LAST) ? SAMPLE : SETTLE;
            end
            SAMPLE: begin
                code_nx = code;
                mcnt_nx = m_inc;
                if (m_inc >= ID_N) begin
                    mcnt_nx    = 16'd0;
                    lcd_id_nx  = dec_id;
                    h_nx       = dec_h;
                    v_nx       = dec_v;
                    clk_sel_nx = dec_clk;
                    id_err_nx  = ~dec_ok;
                    state_nx   = dec_ok ? RST_HOLD : ERROR;
                end
            end
            RST_HOLD: begin
                cnt_nx     = (cnt >= RST_LAST) ? 16'd0 : sat(cnt);
                state_nx   = (cnt >= RST_LAST) ? RUN_WAIT : RST_HOLD;
                lcd_rst_nx = cnt >= RST_LAST;
                drv_en_nx  = cnt >= RST_LAST;
            end
            RUN_WAIT: begin
                if (vs_rise) begin
                    cnt_nx    = sat(cnt);
                    lcd_bl_nx = sat(cnt) >= BL_N;
                    state_nx  = (sat(cnt) >= BL_N) ? ON : RUN_WAIT;
                end
            end
            default: ;
        endcase
        if (restart) begin
            state_nx   = SETTLE;
            cnt_nx     = 16'd0;
            mcnt_nx    = 16'd0;
            code_nx    = 3'd0;
            drv_en_nx  = 1'b0;
            lcd_rst_nx = 1'b0;
            lcd_bl_nx  = 1'b0;
            id_err_nx  = 1'b0;
            lcd_id_nx  = lcd_id;
            h_nx       = h_disp;
            v_nx       = v_disp;
            clk_sel_nx = clk_sel;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= SETTLE;
            cnt     <= '0;
            mcnt    <= '0;
            code_q  <= '0;
            vs_q    <= '0;
            drv_en  <= 1'b0;
            lcd_rst <= 1'b0;
            lcd_bl  <= 1'b0;
            id_err  <= 1'b0;
            lcd_id  <= '0;
            h_disp  <= '0;
            v_disp  <= '0;
            clk_sel <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            mcnt    <= mcnt_nx;
            code_q  <= code_nx;
            vs_q    <= {vs_q[1:0], lcd_vs};
            drv_en  <= drv_en_nx;
            lcd_rst <= lcd_rst_nx;
            lcd_bl  <= lcd_bl_nx;
            id_err  <= id_err_nx;
            lcd_id  <= lcd_id_nx;
            h_disp  <= h_nx;
            v_disp  <= v_nx;
            clk_sel <= clk_sel_nx;
        end
    end
endmodule

// File: tb/tb_lcd_init_ctrl.sv
// tb_lcd_init_ctrl: randomized scenarios checked every cycle against an event-time reference model
module tb_lcd_init_ctrl;
    localparam int TS = 4, NS = 4, TR = 8, BF = 2;

    logic        sys_clk = 1'b0, sys_rst_n = 1'b0, restart = 1'b0, lcd_vs = 1'b0;
    logic [23:0] lcd_rgb_i = '0;
    logic        drv_en, lcd_rst, lcd_bl, id_err;
    logic [15:0] lcd_id;
    logic [10:0] h_disp, v_disp;
    logic [1:0]  clk_sel;

    lcd_init_ctrl #(.T_SETTLE(TS), .ID_SAMPLES(NS), .T_RST(TR), .BL_FRAMES(BF)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .restart(restart), .lcd_rgb_i(lcd_rgb_i),
        .lcd_vs(lcd_vs), .drv_en(drv_en), .lcd_rst(lcd_rst), .lcd_bl(lcd_bl), .lcd_id(lcd_id),
        .h_disp(h_disp), .v_disp(v_disp), .clk_sel(clk_sel), .id_err(id_err)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_cmp = 0, n_bad = 0;
    logic [2:0]  codes[$];
    logic        vss[$], vhist[$];
    logic [15:0] e_id = '0;
    logic [10:0] e_h = '0, e_v = '0;
    logic [1:0]  e_clk = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic ref_dec(input logic [2:0] c, output logic [15:0] id,
                                     output logic [10:0] h, output logic [10:0] v, output logic [1:0] k);
        {id, h, v, k} = '0;
        case (c)
            3'b000: {id, h, v, k} = {16'h4342, 11'd480, 11'd272, 2'd0};
            3'b001: {id, h, v, k} = {16'h7084, 11'd800, 11'd480, 2'd1};
            3'b010: {id, h, v, k} = {16'h7016, 11'd1024, 11'd600, 2'd2};
            3'b100: {id, h, v, k} = {16'h4384, 11'd800, 11'd480, 2'd1};
            3'b101: {id, h, v, k} = {16'h1018, 11'd1280, 11'd800, 2'd3};
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic logic vs_at(input int g);
        return (g >= 0 && g < vhist.size()) ? vhist[g] : 1'b0;
    endfunction

    task automatic gen_codes(input int n, input int mode, input logic [2:0] c0);
        codes.delete();
        for (int c = 0; c < n; c++) begin
            if (mode == 0) codes.push_back(c0);
            else if (mode == 1) codes.push_back((c < TS + 7 && c % 2 == 1) ? 3'b001 : 3'b000);
            else if (c == 0 || $urandom_range(0, 3) == 0) codes.push_back(3'($urandom));
            else codes.push_back(codes[c-1]);
        end
    endtask

    task automatic gen_vs(input int n, input int period, input int start);
        vss.delete();
        for (int c = 0; c < n; c++)
            vss.push_back(period > 0 && ((c + start) % period) < period / 2);
    endtask

    task automatic run(input int n);
        int a = -1, r, b = -1, edges = 0;
        logic ok = 1'b0;
        logic [15:0] d_id;
        logic [10:0] d_h, d_v;
        logic [1:0]  d_k;
        for (int c = TS + NS - 1; c < n && a < 0; c++) begin
            int same = 1;
            for (int j = c - NS + 1; j < c; j++) if (codes[j] != codes[c]) same = 0;
            if (same == 1) a = c;
        end
        if (a >= 0) ok = ref_dec(codes[a], d_id, d_h, d_v, d_k);
        r = a + 1 + TR;
        for (int c = 0; c < n; c++) begin
            int g, k;
            logic acc, drv, bl;
            lcd_rgb_i     = 24'($urandom);
            lcd_rgb_i[7]  = codes[c][2];
            lcd_rgb_i[15] = codes[c][1];
            lcd_rgb_i[23] = codes[c][0];
            lcd_vs        = vss[c];
            vhist.push_back(vss[c]);
            g = vhist.size() - 1;
            if (a >= 0 && ok && c >= r && b < 0 && vs_at(g - 2) && !vs_at(g - 3)) begin
                edges++;
                if (edges == BF) b = c;
            end
            @(posedge sys_clk);
            #1;
            k   = c + 1;
            acc = a >= 0 && k > a;
            drv = acc && ok && k >= r;
            bl  = b >= 0 && k > b;
            if (acc) {e_id, e_h, e_v, e_clk} = {d_id, d_h, d_v, d_k};
            check("ctl", 64'({drv_en, lcd_rst, lcd_bl, id_err}), 64'({drv, drv, bl, acc && !ok}));
            check("id", 64'({lcd_id, h_disp, v_disp, clk_sel}), 64'({e_id, e_h, e_v, e_clk}));
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        lcd_vs  = 1'b0;
        vhist.push_back(1'b0);
        @(posedge sys_clk);
        #1;
        restart = 1'b0;
        check("restart_ctl", 64'({drv_en, lcd_rst, lcd_bl, id_err}), 64'd0);
        check("restart_id", 64'({lcd_id, h_disp, v_disp, clk_sel}), 64'({e_id, e_h, e_v, e_clk}));
    endtask

    task automatic do_reset();
        #2;
        sys_rst_n = 1'b0;
        #1;
        {e_id, e_h, e_v, e_clk} = '0;
        vhist.delete();
        check("reset_ctl", 64'({drv_en, lcd_rst, lcd_bl, id_err}), 64'd0);
        check("reset_id", 64'({lcd_id, h_disp, v_disp, clk_sel}), 64'd0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        gen_codes(60, 0, 3'b001); gen_vs(60, 6, $urandom_range(0, 5)); run(60);
        do_restart();
        gen_codes(50, 1, 3'b000); gen_vs(50, 0, 0); run(50);
        do_restart();
        gen_codes(60, 0, 3'b111); gen_vs(60, 4, 0); run(60);
        do_restart();
        gen_codes(60, 0, 3'b010); gen_vs(60, 5, $urandom_range(0, 4)); run(60);
        do_restart();
        gen_codes(60, 0, 3'b101); gen_vs(60, 6, $urandom_range(0, 5)); run(60);
        repeat (8) begin
            do_restart();
            gen_codes(80, 2, 3'($urandom));
            gen_vs(80, $urandom_range(3, 10), $urandom_range(0, 9));
            run(80);
        end
        do_restart();
        gen_codes(TS + NS + TR + 3, 0, 3'b100); gen_vs(TS + NS + TR + 3, 0, 0); run(TS + NS + TR + 3);
        do_reset();
        gen_codes(60, 0, 3'b001); gen_vs(60, 6, $urandom_range(0, 5)); run(60);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
